// File: rtl/r5p_soc_pkg.sv
// +----------------------------------------------------------------------------+
// | r5p_soc_pkg : SoC peripheral bus types and address map                     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package r5p_soc_pkg;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned BEN_W = DAT_W / 8;

  typedef logic [ADR_W-1:0] adr_t;
  typedef logic [DAT_W-1:0] dat_t;
  typedef logic [BEN_W-1:0] ben_t;

  localparam adr_t GPIO_BASE   = 32'h8000_0000;
  localparam adr_t UART_BASE   = 32'h8000_0010;
  localparam adr_t PERIPH_MASK = 32'hFFFF_FFF0;

  // Index width for an n-way mux; a single subordinate still needs one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/r5p_soc_bus_dec.sv
// +----------------------------------------------------------------------------+
// | r5p_soc_bus_dec : address decoder, one-hot select with lowest-index win    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module r5p_soc_bus_dec
  import r5p_soc_pkg::*;
#(
  parameter int unsigned              SN = 2,
  parameter int unsigned              AW = 32,
  parameter logic [SN-1:0][AW-1:0]    AS = {UART_BASE, GPIO_BASE},
  parameter logic [SN-1:0][AW-1:0]    AM = {PERIPH_MASK, PERIPH_MASK}
) (
  input  logic [AW-1:0] adr_i,
  output logic [SN-1:0] sel_o,
  output logic          miss_o
);

  logic [SN-1:0] hit;

  generate
    for (genvar i = 0; i < SN; i++) begin : g_hit
      assign hit[i] = ((adr_i & AM[i]) == (AS[i] & AM[i]));
    end
  endgenerate

  // Scan from the top down so the lowest-index hit is the last one written.
  always_comb begin
    sel_o = '0;
    for (int i = SN - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_o    = '0;
        sel_o[i] = 1'b1;
      end
    end
  end

  assign miss_o = ~|hit;

endmodule

`default_nettype wire

// File: rtl/r5p_soc_bus_dmx.sv
// +----------------------------------------------------------------------------+
// | r5p_soc_bus_dmx : 1-to-SN peripheral bus demux with decode-error responder |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module r5p_soc_bus_dmx
  import r5p_soc_pkg::*;
#(
  parameter int unsigned              SN = 2,
  parameter int unsigned              AW = 32,
  parameter int unsigned              DW = 32,
  parameter int unsigned              BW = DW / 8,
  parameter logic [SN-1:0][AW-1:0]    AS = {UART_BASE, GPIO_BASE},
  parameter logic [SN-1:0][AW-1:0]    AM = {PERIPH_MASK, PERIPH_MASK}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m_vld,
  input  logic                   m_wen,
  input  logic [AW-1:0]          m_adr,
  input  logic [BW-1:0]          m_ben,
  input  logic [DW-1:0]          m_wdt,
  output logic [DW-1:0]          m_rdt,
  output logic                   m_rdy,
  output logic                   m_err,
  output logic [SN-1:0]          s_vld,
  output logic                   s_wen,
  output logic [AW-1:0]          s_adr,
  output logic [BW-1:0]          s_ben,
  output logic [DW-1:0]          s_wdt,
  input  logic [SN-1:0][DW-1:0]  s_rdt,
  input  logic [SN-1:0]          s_rdy
);

  localparam int unsigned IW = idx_w(SN);

  function automatic logic [IW-1:0] enc(input logic [SN-1:0] oh);
    enc = '0;
    for (int i = 0; i < SN; i++) begin
      if (oh[i]) enc = enc | IW'(i);
    end
  endfunction

  logic [SN-1:0] sel;
  logic          miss;
  logic          hs;
  logic [SN-1:0] sel_q, sel_d;
  logic          err_q, err_d;
  logic          hs_q,  hs_d;

  r5p_soc_bus_dec #(
    .SN (SN),
    .AW (AW),
    .AS (AS),
    .AM (AM)
  ) u_dec (
    .adr_i  (m_adr),
    .sel_o  (sel),
    .miss_o (miss)
  );

  // Unmapped accesses are acknowledged immediately by the error responder.
  assign m_rdy = miss | s_rdy[enc(sel)];
  assign hs    = m_vld & m_rdy;

  // Valids are also held low during reset so no peripheral sees a stray request.
  assign s_vld = {SN{m_vld & ~rst}} & sel;
  assign s_wen = m_wen;
  assign s_adr = m_adr;
  assign s_ben = m_ben;
  assign s_wdt = m_wdt;

  always_comb begin
    sel_d = sel_q;
    err_d = err_q;
    hs_d  = hs;
    if (hs) begin
      sel_d = sel;
      err_d = miss;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= '0;
      err_q <= 1'b0;
      hs_q  <= 1'b0;
    end else begin
      sel_q <= sel_d;
      err_q <= err_d;
      hs_q  <= hs_d;
    end
  end

  assign m_rdt = (|sel_q) ? s_rdt[enc(sel_q)] : '0;
  assign m_err = err_q & hs_q;

endmodule

`default_nettype wire

// File: tb/tb_r5p_soc_bus_dmx.sv
// +----------------------------------------------------------------------------+
// | tb_r5p_soc_bus_dmx : scoreboard bench for the peripheral bus demux         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_r5p_soc_bus_dmx;

  localparam logic [31:0] C_GPIO = 32'h8000_0000;
  localparam logic [31:0] C_UART = 32'h8000_0010;
  localparam logic [31:0] C_MASK = 32'hFFFF_FFF0;

  typedef struct {
    int   sel;
    logic err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             m_vld;
  logic             m_wen;
  logic [31:0]      m_adr;
  logic [3:0]       m_ben;
  logic [31:0]      m_wdt;
  logic [31:0]      m_rdt;
  logic             m_rdy;
  logic             m_err;
  logic [1:0]       s_vld;
  logic             s_wen;
  logic [31:0]      s_adr;
  logic [3:0]       s_ben;
  logic [31:0]      s_wdt;
  logic [1:0][31:0] s_rdt;
  logic [1:0]       s_rdy;

  exp_t sb[$];
  int   msel = -1;
  int   n_chk = 0;
  int   n_fail = 0;

  r5p_soc_bus_dmx u_dut (
    .clk   (clk),
    .rst   (rst),
    .m_vld (m_vld),
    .m_wen (m_wen),
    .m_adr (m_adr),
    .m_ben (m_ben),
    .m_wdt (m_wdt),
    .m_rdt (m_rdt),
    .m_rdy (m_rdy),
    .m_err (m_err),
    .s_vld (s_vld),
    .s_wen (s_wen),
    .s_adr (s_adr),
    .s_ben (s_ben),
    .s_wdt (s_wdt),
    .s_rdt (s_rdt),
    .s_rdy (s_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Registered side: compare data/error phase against the oldest handshake.
  task automatic check_data();
    exp_t        e;
    logic        exp_err;
    logic [31:0] exp_rdt;
    exp_err = 1'b0;
    if (sb.size() > 0) begin
      e       = sb.pop_front();
      msel    = e.sel;
      exp_err = e.err;
    end
    exp_rdt = (msel == 0) ? s_rdt[0] : (msel == 1) ? s_rdt[1] : 32'h0;
    check("m_rdt", {32'h0, m_rdt}, {32'h0, exp_rdt});
    check("m_err", {63'h0, m_err}, {63'h0, exp_err});
  endtask

  task automatic cycle(input logic vld, input logic wen, input logic [31:0] adr,
                       input logic [31:0] wdt, input logic [1:0] rdy);
    int         esel;
    logic       erdy;
    logic [1:0] evld;
    @(negedge clk);
    check_data();
    m_vld = vld;
    m_wen = wen;
    m_adr = adr;
    m_wdt = wdt;
    s_rdy = rdy;
    #1;
    if      ((adr & C_MASK) == (C_GPIO & C_MASK)) esel = 0;
    else if ((adr & C_MASK) == (C_UART & C_MASK)) esel = 1;
    else                                          esel = -1;
    erdy = (esel < 0) ? 1'b1 : rdy[esel];
    evld = !vld ? 2'b00 : (esel == 0) ? 2'b01 : (esel == 1) ? 2'b10 : 2'b00;
    check("m_rdy", {63'h0, m_rdy}, {63'h0, erdy});
    check("s_vld", {62'h0, s_vld}, {62'h0, evld});
    if (vld && erdy) sb.push_back('{esel, (esel < 0)});
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 2'b11);
  endtask

  initial begin
    rst   = 1'b1;
    m_vld = 1'b0;
    m_wen = 1'b0;
    m_adr = '0;
    m_ben = 4'hF;
    m_wdt = '0;
    s_rdy = 2'b11;
    s_rdt[0] = 32'hDEAD_0000;
    s_rdt[1] = 32'hBEEF_0001;

    repeat (2) @(negedge clk);
    check("rst_rdt", {32'h0, m_rdt}, 64'h0);
    check("rst_err", {63'h0, m_err}, 64'h0);
    check("rst_vld", {62'h0, s_vld}, 64'h0);
    rst = 1'b0;

    // Reset in the data phase of a read: pending data is dropped.
    cycle(1'b0, 1'b0, C_GPIO, 32'h0, 2'b11);
    cycle(1'b1, 1'b0, C_GPIO, 32'h0, 2'b11);
    @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    msel = -1;
    #1;
    check("midrst_rdt", {32'h0, m_rdt}, 64'h0);
    check("midrst_err", {63'h0, m_err}, 64'h0);
    check("midrst_vld", {62'h0, s_vld}, 64'h0);
    @(negedge clk);
    rst   = 1'b0;
    m_vld = 1'b0;

    // Write to GPIO: only subordinate 0 sees a valid, broadcast data intact.
    cycle(1'b1, 1'b1, 32'h8000_0004, 32'hA5A5_0001, 2'b11);
    check("s_wdt", {32'h0, s_wdt}, {32'h0, 32'hA5A5_0001});
    check("s_wen", {63'h0, s_wen}, 64'h1);
    check("s_adr", {32'h0, s_adr}, {32'h0, 32'h8000_0004});
    idle();

    // Single read from UART.
    s_rdt[1] = 32'h1234_5678;
    cycle(1'b1, 1'b0, C_UART, 32'h0, 2'b11);
    idle();

    // Back-to-back reads across both subordinates.
    s_rdt[0] = 32'h0000_0011;
    s_rdt[1] = 32'h0000_0022;
    cycle(1'b1, 1'b0, C_GPIO, 32'h0, 2'b11);
    cycle(1'b1, 1'b0, C_UART, 32'h0, 2'b11);
    idle();

    // Stall on GPIO for three cycles, then complete.
    s_rdt[0] = 32'h0BAD_F00D;
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 32'h8000_0008, 32'h0, 2'b10);
    cycle(1'b1, 1'b0, 32'h8000_0008, 32'h0, 2'b11);
    idle();

    // Unmapped read: immediate ready, one-cycle error pulse, zero data.
    cycle(1'b1, 1'b0, 32'h0000_1000, 32'h0, 2'b11);
    idle();
    idle();

    // Unmapped write also flags.
    cycle(1'b1, 1'b1, 32'h4000_0000, 32'h1, 2'b00);
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
